// File: rtl/ocx_tlx_data_flit_sched_if.sv
// Handshake and status bundle between the TLX control path and the data-flit scheduler.
interface ocx_tlx_data_flit_sched_if #(
    parameter int unsigned DESC_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DESC_DEPTH) + 1;

    logic             desc_v;
    logic [1:0]       desc_vc;
    logic [1:0]       desc_flit_cnt;
    logic             desc_cfg_hint;
    logic [3:0]       desc_cfg_offset;
    logic             data_flit_v;
    logic             data_flit_bdi;

    logic             xfer_v;
    logic [1:0]       xfer_vc;
    logic             xfer_last;
    logic             xfer_cfg_hint;
    logic [3:0]       xfer_cfg_offset;
    logic             done_vc0;
    logic             done_vc1;
    logic             done_bdi;
    logic             q_empty;
    logic             q_full;
    logic [CNT_W-1:0] q_count;
    logic             err_overflow;
    logic             err_orphan;
    logic             err_bad_len;

    modport master (
        output desc_v, desc_vc, desc_flit_cnt, desc_cfg_hint, desc_cfg_offset,
               data_flit_v, data_flit_bdi,
        input  xfer_v, xfer_vc, xfer_last, xfer_cfg_hint, xfer_cfg_offset,
               done_vc0, done_vc1, done_bdi, q_empty, q_full, q_count,
               err_overflow, err_orphan, err_bad_len
    );

    modport slave (
        input  desc_v, desc_vc, desc_flit_cnt, desc_cfg_hint, desc_cfg_offset,
               data_flit_v, data_flit_bdi,
        output xfer_v, xfer_vc, xfer_last, xfer_cfg_hint, xfer_cfg_offset,
               done_vc0, done_vc1, done_bdi, q_empty, q_full, q_count,
               err_overflow, err_orphan, err_bad_len
    );
endinterface

// File: rtl/ocx_tlx_data_flit_sched.sv
// Data-flit scheduler: queues per-command descriptors in parse order and binds each
// incoming 64B data flit to the oldest open command, pulsing per-VC completion.
module ocx_tlx_data_flit_sched #(
    parameter int unsigned DESC_DEPTH = 8
) (
    input  logic                          tlx_clk,
    input  logic                          reset_n,
    ocx_tlx_data_flit_sched_if.slave      io_sched
);
    localparam int unsigned PTR_W = $clog2(DESC_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [1:0] vc;
        logic [2:0] len;
        logic       cfg_hint;
        logic [3:0] cfg_offset;
    } desc_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    desc_t            r_mem [DESC_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    state_t           r_state;
    logic [2:0]       r_remain;
    logic             r_bdi_acc;
    logic [1:0]       r_act_vc;
    logic             r_act_cfg_hint;
    logic [3:0]       r_act_cfg_offset;

    logic             r_xfer_v;
    logic [1:0]       r_xfer_vc;
    logic             r_xfer_last;
    logic             r_xfer_cfg_hint;
    logic [3:0]       r_xfer_cfg_offset;
    logic             r_done_vc0;
    logic             r_done_vc1;
    logic             r_done_bdi;
    logic             r_err_overflow;
    logic             r_err_orphan;
    logic             r_err_bad_len;

    logic [2:0]       w_len;
    logic             w_vc_ok;
    logic             w_desc_legal;
    logic             w_desc_bad;
    desc_t            w_new_desc;
    desc_t            w_head;
    logic             w_head_v;
    logic             w_idle_flit;
    logic             w_pop;
    logic             w_bypass;
    logic             w_orphan;
    logic             w_push;
    logic             w_overflow;
    logic [2:0]       w_remain_dec;
    logic             w_bdi_busy;
    logic [CNT_W-1:0] w_count_nxt;

    // dLength decode; 00 is illegal and maps to zero flits
    always_comb begin
        w_len = 3'd0;
        case (io_sched.desc_flit_cnt)
            2'b01:   w_len = 3'd1;
            2'b10:   w_len = 3'd2;
            2'b11:   w_len = 3'd4;
            default: w_len = 3'd0;
        endcase
    end

    assign w_vc_ok      = (io_sched.desc_vc == 2'b01) || (io_sched.desc_vc == 2'b10);
    assign w_desc_legal = io_sched.desc_v & (w_len != 3'd0) & w_vc_ok;
    assign w_desc_bad   = io_sched.desc_v & ~((w_len != 3'd0) & w_vc_ok);

    assign w_new_desc = '{vc:         io_sched.desc_vc,
                          len:        w_len,
                          cfg_hint:   io_sched.desc_cfg_hint,
                          cfg_offset: io_sched.desc_cfg_offset};

    // Only an IDLE flit opens a command; an empty FIFO may be bypassed by a same-cycle descriptor
    assign w_idle_flit = io_sched.data_flit_v & (r_state == S_IDLE);
    assign w_pop       = w_idle_flit & ~r_empty;
    assign w_bypass    = w_idle_flit & r_empty & w_desc_legal;
    assign w_orphan    = w_idle_flit & r_empty & ~w_desc_legal;
    assign w_head_v    = w_pop | w_bypass;
    assign w_head      = w_pop ? r_mem[r_rd_ptr] : w_new_desc;

    assign w_push     = w_desc_legal & ~w_bypass & (~r_full | w_pop);
    assign w_overflow = w_desc_legal & ~w_bypass & r_full & ~w_pop;

    assign w_remain_dec = r_remain - 3'd1;
    assign w_bdi_busy   = r_bdi_acc | io_sched.data_flit_bdi;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Descriptor storage; contents are don't-care until written
    always_ff @(posedge tlx_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_desc;
        end
    end

    // FIFO pointers and registered occupancy flags
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DESC_DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Sticky error flags
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            r_err_overflow <= 1'b0;
            r_err_orphan   <= 1'b0;
            r_err_bad_len  <= 1'b0;
        end else begin
            r_err_overflow <= r_err_overflow | w_overflow;
            r_err_orphan   <= r_err_orphan | w_orphan;
            r_err_bad_len  <= r_err_bad_len | w_desc_bad;
        end
    end

    // Flit-binding FSM with registered transfer and completion outputs
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_remain          <= 3'd0;
            r_bdi_acc         <= 1'b0;
            r_act_vc          <= 2'b00;
            r_act_cfg_hint    <= 1'b0;
            r_act_cfg_offset  <= 4'h0;
            r_xfer_v          <= 1'b0;
            r_xfer_vc         <= 2'b00;
            r_xfer_last       <= 1'b0;
            r_xfer_cfg_hint   <= 1'b0;
            r_xfer_cfg_offset <= 4'h0;
            r_done_vc0        <= 1'b0;
            r_done_vc1        <= 1'b0;
            r_done_bdi        <= 1'b0;
        end else begin
            r_xfer_v          <= 1'b0;
            r_xfer_vc         <= 2'b00;
            r_xfer_last       <= 1'b0;
            r_xfer_cfg_hint   <= 1'b0;
            r_xfer_cfg_offset <= 4'h0;
            r_done_vc0        <= 1'b0;
            r_done_vc1        <= 1'b0;
            r_done_bdi        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_head_v) begin
                        r_act_vc          <= w_head.vc;
                        r_act_cfg_hint    <= w_head.cfg_hint;
                        r_act_cfg_offset  <= w_head.cfg_offset;
                        r_xfer_v          <= 1'b1;
                        r_xfer_vc         <= w_head.vc;
                        r_xfer_cfg_hint   <= w_head.cfg_hint;
                        r_xfer_cfg_offset <= w_head.cfg_offset;
                        r_bdi_acc         <= io_sched.data_flit_bdi;
                        r_remain          <= w_head.len - 3'd1;
                        if (w_head.len == 3'd1) begin
                            r_xfer_last <= 1'b1;
                            r_done_vc0  <= w_head.vc[0];
                            r_done_vc1  <= w_head.vc[1];
                            r_done_bdi  <= io_sched.data_flit_bdi;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (io_sched.data_flit_v) begin
                        r_xfer_v          <= 1'b1;
                        r_xfer_vc         <= r_act_vc;
                        r_xfer_cfg_hint   <= r_act_cfg_hint;
                        r_xfer_cfg_offset <= r_act_cfg_offset;
                        r_remain          <= w_remain_dec;
                        r_bdi_acc         <= w_bdi_busy;
                        if (w_remain_dec == 3'd0) begin
                            r_xfer_last <= 1'b1;
                            r_done_vc0  <= r_act_vc[0];
                            r_done_vc1  <= r_act_vc[1];
                            r_done_bdi  <= w_bdi_busy;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_sched.xfer_v          = r_xfer_v;
    assign io_sched.xfer_vc         = r_xfer_vc;
    assign io_sched.xfer_last       = r_xfer_last;
    assign io_sched.xfer_cfg_hint   = r_xfer_cfg_hint;
    assign io_sched.xfer_cfg_offset = r_xfer_cfg_offset;
    assign io_sched.done_vc0        = r_done_vc0;
    assign io_sched.done_vc1        = r_done_vc1;
    assign io_sched.done_bdi        = r_done_bdi;
    assign io_sched.q_empty         = r_empty;
    assign io_sched.q_full          = r_full;
    assign io_sched.q_count         = r_count;
    assign io_sched.err_overflow    = r_err_overflow;
    assign io_sched.err_orphan      = r_err_orphan;
    assign io_sched.err_bad_len     = r_err_bad_len;

endmodule

// File: tb/tb_ocx_tlx_data_flit_sched.sv
// Bench for the data-flit scheduler: hand-derived vector table, directed corner sequences,
// and a queue-based reference model feeding a per-cycle scoreboard.
module tb_ocx_tlx_data_flit_sched;
    localparam int unsigned DEPTH = 8;

    logic tlx_clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 tlx_clk = ~tlx_clk;

    ocx_tlx_data_flit_sched_if #(.DESC_DEPTH(DEPTH)) sif ();

    ocx_tlx_data_flit_sched #(.DESC_DEPTH(DEPTH)) dut (
        .tlx_clk  (tlx_clk),
        .reset_n  (reset_n),
        .io_sched (sif.slave)
    );

    typedef struct packed {
        logic       xv;
        logic [1:0] xvc;
        logic       xlast;
        logic       xhint;
        logic [3:0] xoff;
        logic       d0;
        logic       d1;
        logic       dbdi;
        logic [3:0] qcnt;
        logic       qfull;
        logic       qempty;
        logic       eov;
        logic       eor;
        logic       ebl;
    } out_t;

    typedef struct packed {
        logic [1:0] vc;
        logic [1:0] cnt;
        logic       hint;
        logic [3:0] off;
    } mdesc_t;

    typedef struct {
        logic       dv;
        logic [1:0] dvc;
        logic [1:0] dcnt;
        logic       dhint;
        logic [3:0] doff;
        logic       fv;
        logic       bdi;
        out_t       exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    out_t   sb_q[$];
    mdesc_t m_q[$];
    bit     m_busy;
    int     m_rem;
    bit     m_bdi;
    mdesc_t m_act;
    bit     m_eov, m_eor, m_ebl;

    function automatic out_t mk(input logic xv, input logic [1:0] xvc, input logic xlast,
                                input logic xhint, input logic [3:0] xoff, input logic d0,
                                input logic d1, input logic dbdi, input int q);
        out_t o;
        o        = '0;
        o.xv     = xv;
        o.xvc    = xvc;
        o.xlast  = xlast;
        o.xhint  = xhint;
        o.xoff   = xoff;
        o.d0     = d0;
        o.d1     = d1;
        o.dbdi   = dbdi;
        o.qcnt   = 4'(q);
        o.qfull  = (q == int'(DEPTH));
        o.qempty = (q == 0);
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.xv     = sif.xfer_v;
        o.xvc    = sif.xfer_vc;
        o.xlast  = sif.xfer_last;
        o.xhint  = sif.xfer_cfg_hint;
        o.xoff   = sif.xfer_cfg_offset;
        o.d0     = sif.done_vc0;
        o.d1     = sif.done_vc1;
        o.dbdi   = sif.done_bdi;
        o.qcnt   = sif.q_count;
        o.qfull  = sif.q_full;
        o.qempty = sif.q_empty;
        o.eov    = sif.err_overflow;
        o.eor    = sif.err_orphan;
        o.ebl    = sif.err_bad_len;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t got, input out_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %p required %p", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Behavioural reference: descriptor queue plus an open-command tracker
    task automatic model_step(input logic rst, input logic dv, input logic [1:0] dvc,
                              input logic [1:0] dcnt, input logic dhint, input logic [3:0] doff,
                              input logic fv, input logic bdi, output out_t e);
        mdesc_t nd, h;
        bit     legal, have_h, bypass;
        int     n;
        e = '0;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_rem = 0; m_bdi = 0;
            m_eov = 0; m_eor = 0; m_ebl = 0;
            e.qempty = 1'b1;
            return;
        end
        legal  = dv && (dcnt != 2'b00) && (dvc == 2'b01 || dvc == 2'b10);
        nd     = '{vc: dvc, cnt: dcnt, hint: dhint, off: doff};
        have_h = 0;
        bypass = 0;
        h      = '0;
        if (dv && !legal) m_ebl = 1;
        if (fv) begin
            if (m_busy) begin
                m_rem  = m_rem - 1;
                m_bdi  = m_bdi | bdi;
                e.xv = 1'b1; e.xvc = m_act.vc; e.xhint = m_act.hint; e.xoff = m_act.off;
                if (m_rem == 0) begin
                    e.xlast = 1'b1; e.d0 = m_act.vc[0]; e.d1 = m_act.vc[1]; e.dbdi = m_bdi;
                    m_busy = 0;
                end
            end else begin
                if (m_q.size() > 0) begin
                    h = m_q.pop_front(); have_h = 1;
                end else if (legal) begin
                    h = nd; have_h = 1; bypass = 1;
                end else begin
                    m_eor = 1;
                end
                if (have_h) begin
                    n     = (h.cnt == 2'b11) ? 4 : int'(h.cnt);
                    m_act = h;
                    m_bdi = bdi;
                    m_rem = n - 1;
                    e.xv = 1'b1; e.xvc = h.vc; e.xhint = h.hint; e.xoff = h.off;
                    if (m_rem == 0) begin
                        e.xlast = 1'b1; e.d0 = h.vc[0]; e.d1 = h.vc[1]; e.dbdi = bdi;
                    end else begin
                        m_busy = 1;
                    end
                end
            end
        end
        if (legal && !bypass) begin
            if (m_q.size() < int'(DEPTH)) m_q.push_back(nd);
            else                          m_eov = 1;
        end
        e.qcnt   = 4'(m_q.size());
        e.qfull  = (m_q.size() == int'(DEPTH));
        e.qempty = (m_q.size() == 0);
        e.eov    = m_eov;
        e.eor    = m_eor;
        e.ebl    = m_ebl;
    endtask

    // One clock: drive, predict into scoreboard, sample after the edge, compare
    task automatic cycle(input logic rst, input logic dv, input logic [1:0] dvc,
                         input logic [1:0] dcnt, input logic dhint, input logic [3:0] doff,
                         input logic fv, input logic bdi, output out_t got);
        out_t e;
        reset_n             = ~rst;
        sif.desc_v          = dv;
        sif.desc_vc         = dvc;
        sif.desc_flit_cnt   = dcnt;
        sif.desc_cfg_hint   = dhint;
        sif.desc_cfg_offset = doff;
        sif.data_flit_v     = fv;
        sif.data_flit_bdi   = bdi;
        model_step(rst, dv, dvc, dcnt, dhint, doff, fv, bdi, e);
        sb_q.push_back(e);
        @(posedge tlx_clk);
        #1;
        n_cyc++;
        got = sample();
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            check_out($sformatf("model_cyc%0d", n_cyc), got, sb_q.pop_front());
        end
    endtask

    task automatic idle(output out_t got);
        cycle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, got);
    endtask

    task automatic do_reset(output out_t got);
        cycle(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, got);
        cycle(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, got);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[14];
        out_t got;

        vecs[0]  = '{1'b1, 2'b01, 2'b10, 1'b0, 4'h0, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 1)};
        vecs[1]  = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, mk(1, 2'b01, 0, 0, 4'h0, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, mk(1, 2'b01, 1, 0, 4'h0, 1, 0, 0, 0)};
        vecs[3]  = '{1'b1, 2'b10, 2'b01, 1'b1, 4'h5, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 1)};
        vecs[4]  = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, mk(1, 2'b10, 1, 1, 4'h5, 0, 1, 0, 0)};
        vecs[5]  = '{1'b1, 2'b01, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, mk(1, 2'b01, 1, 0, 4'h0, 1, 0, 0, 0)};
        vecs[6]  = '{1'b1, 2'b01, 2'b11, 1'b0, 4'h3, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 1)};
        vecs[7]  = '{1'b1, 2'b10, 2'b01, 1'b0, 4'h0, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 2)};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, mk(1, 2'b01, 0, 0, 4'h3, 0, 0, 0, 1)};
        vecs[9]  = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, mk(1, 2'b01, 0, 0, 4'h3, 0, 0, 0, 1)};
        vecs[10] = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b1, mk(1, 2'b01, 0, 0, 4'h3, 0, 0, 0, 1)};
        vecs[11] = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, mk(1, 2'b01, 1, 0, 4'h3, 1, 0, 1, 1)};
        vecs[12] = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, mk(1, 2'b10, 1, 0, 4'h0, 0, 1, 0, 0)};
        vecs[13] = '{1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 0)};

        do_reset(got);
        check_out("reset_state", got, mk(0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 0));

        // Table: 2-flit VC0, 1-flit VC1 cfg, bypass, 4-flit with bdi, back-to-back next command
        foreach (vecs[i]) begin
            cycle(1'b0, vecs[i].dv, vecs[i].dvc, vecs[i].dcnt, vecs[i].dhint, vecs[i].doff,
                  vecs[i].fv, vecs[i].bdi, got);
            check_out($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Fill to full, overflow drop, then push coincident with a pop
        do_reset(got);
        for (int i = 0; i < int'(DEPTH); i++)
            cycle(1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 4'(i), 1'b0, 1'b0, got);
        check_val("fill_q_count", int'(got.qcnt), 8);
        check_val("fill_q_full", int'(got.qfull), 1);
        cycle(1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 4'hF, 1'b0, 1'b0, got);
        check_val("ovf_err_overflow", int'(got.eov), 1);
        check_val("ovf_q_count", int'(got.qcnt), 8);
        cycle(1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 4'h9, 1'b1, 1'b0, got);
        check_val("pushpop_q_count", int'(got.qcnt), 8);
        check_val("pushpop_done_vc0", int'(got.d0), 1);
        check_val("pushpop_xfer_off", int'(got.xoff), 0);
        for (int i = 0; i < int'(DEPTH); i++)
            cycle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, got);
        check_val("drain_last_vc", int'(got.xvc), 2);
        check_val("drain_last_off", int'(got.xoff), 9);
        check_val("drain_done_vc1", int'(got.d1), 1);
        check_val("drain_q_empty", int'(got.qempty), 1);

        // Orphan flit and illegal length / non-one-hot VC
        do_reset(got);
        cycle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, got);
        check_val("orphan_err", int'(got.eor), 1);
        check_val("orphan_xfer_v", int'(got.xv), 0);
        cycle(1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, got);
        check_val("badlen_err", int'(got.ebl), 1);
        check_val("badlen_q_count", int'(got.qcnt), 0);
        do_reset(got);
        cycle(1'b0, 1'b1, 2'b11, 2'b01, 1'b0, 4'h0, 1'b0, 1'b0, got);
        check_val("badvc_err", int'(got.ebl), 1);
        check_val("badvc_q_count", int'(got.qcnt), 0);

        // Reset in the middle of a 4-flit command
        do_reset(got);
        cycle(1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 4'h0, 1'b0, 1'b0, got);
        cycle(1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, got);
        cycle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b1, got);
        cycle(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, got);
        check_out("midbusy_reset", got, mk(0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 0));
        cycle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, got);
        check_val("postreset_xfer_v", int'(got.xv), 0);
        check_val("postreset_done_vc0", int'(got.d0), 0);
        check_val("postreset_orphan", int'(got.eor), 1);

        // Random traffic against the reference model
        do_reset(got);
        for (int i = 0; i < 600; i++) begin
            logic       rdv, rfv, rbdi, rhint, rrst;
            logic [1:0] rvc, rcnt;
            logic [3:0] roff;
            rrst  = ($urandom_range(0, 199) == 0);
            rdv   = ($urandom_range(0, 2) == 0);
            rvc   = ($urandom_range(0, 19) == 0) ? 2'b11 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
            rcnt  = ($urandom_range(0, 19) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            rhint = 1'($urandom_range(0, 1));
            roff  = 4'($urandom_range(0, 15));
            rfv   = ($urandom_range(0, 1) == 0);
            rbdi  = ($urandom_range(0, 5) == 0);
            cycle(rrst, rdv, rvc, rcnt, rhint, roff, rfv, rbdi, got);
        end
        idle(got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
